// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the pipelined adder/subtractor.
//   - MODE_* : bit positions of the per-beat mode word {sat, sgn, sub}
//   - geometry_ok() : elaboration-time legality check for WIDTH/CHUNK/STAGES
//   - sat_value()   : clamp value chosen when a saturating beat overflows
package addsub_pkg;

  localparam int MODE_SUB = 0;
  localparam int MODE_SGN = 1;
  localparam int MODE_SAT = 2;
  localparam int MODE_W   = 3;

  // Widest result sat_value() can build; callers cast down to their width.
  localparam int SAT_MAX_W = 256;

  // The pipeline splits WIDTH into STAGES equal slices, each made of whole
  // CHUNK-bit lookahead groups, so WIDTH must divide evenly by both.
  function automatic bit geometry_ok(input int width, input int chunk, input int stages);
    if (chunk <= 0 || stages < 2 || width > SAT_MAX_W) return 1'b0;
    return (width % (chunk * stages)) == 0;
  endfunction

  // Signed: a result with MSB clear after overflow means the true value went
  // below the minimum (neg + neg wrapped positive), so clamp to 100..0;
  // otherwise clamp to 011..1. Unsigned: add clamps high, sub clamps to zero.
  function automatic logic [SAT_MAX_W-1:0] sat_value(input logic sgn, input logic sub,
                                                      input logic raw_msb, input int width);
    logic [SAT_MAX_W-1:0] ones;
    ones = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
    if (sgn) return raw_msb ? (ones >> 1) : (ones & ~(ones >> 1));
    return sub ? '0 : ones;
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// cla_chunk: N-bit combinational carry-lookahead adder group.
//   a, b  : addends
//   cin   : carry into bit 0
//   s     : sum
//   cout  : carry out of bit N-1
//   gp    : group propagate (every bit propagates, so cout == cin)
module cla_chunk
  import addsub_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         gp
);

  logic [N-1:0] p;
  logic [N-1:0] g;
  logic [N:0]   c;
  logic         term;
  logic         run;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is the flattened lookahead sum-of-products
  // g[i] | p[i]g[i-1] | ... | p[i..0]cin, not a ripple through c[i].
  always_comb begin
    c    = '0;
    term = 1'b0;
    run  = 1'b0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      term = g[i];
      run  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (run & g[j]);
        run  = run & p[j];
      end
      c[i+1] = term | (run & cin);
    end
  end

  assign s    = p ^ c[N-1:0];
  assign cout = c[N];
  assign gp   = &p;

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement adder/subtractor with flags,
// optional saturation and a valid/ready handshake.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand beat handshake
//   a, b, ci              : operands and carry/borrow in
//   sub, sgn, sat         : mode bits travelling with the beat
//   out_valid / out_ready : result beat handshake
//   sum                   : result after saturation
//   cflag, vflag          : carry/borrow out, overflow before saturation
//   zflag, nflag          : zero and negative of sum
//
// Handshake: a beat moves when valid && ready on the same rising edge. The
// whole pipe advances together when the output register is empty or being
// drained (in_ready = !out_valid || out_ready); otherwise every stage holds,
// and out_valid with its sum/flags stay frozen until out_ready.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CHUNK  = 4,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  input  logic             sgn,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cflag,
  output logic             vflag,
  output logic             zflag,
  output logic             nflag
);

  localparam int SL   = WIDTH / STAGES;  // bits resolved per stage
  localparam int NCH  = SL / CHUNK;      // lookahead groups per stage
  localparam int LAST = STAGES - 1;

  if (!geometry_ok(WIDTH, CHUNK, STAGES)) begin : g_bad_geometry
    $error("addsub_pipe: WIDTH must be a multiple of CHUNK*STAGES (STAGES >= 2)");
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage k inputs (st_*) and the slice-k results it produces (nx_*).
  // st_b holds the transformed second operand, so the MSB test for signed
  // overflow sees exactly what the adder saw.
  logic                 st_v [STAGES];
  logic [WIDTH-1:0]     st_a [STAGES];
  logic [WIDTH-1:0]     st_b [STAGES];
  logic [WIDTH-1:0]     st_s [STAGES];
  logic                 st_c [STAGES];
  logic [MODE_W-1:0]    st_m [STAGES];
  logic [WIDTH-1:0]     nx_s [STAGES];
  logic                 nx_c [STAGES];

  // Inter-stage registers; the final stage registers straight into the outputs.
  logic                 r_v [LAST];
  logic [WIDTH-1:0]     r_a [LAST];
  logic [WIDTH-1:0]     r_b [LAST];
  logic [WIDTH-1:0]     r_s [LAST];
  logic                 r_c [LAST];
  logic [MODE_W-1:0]    r_m [LAST];

  logic [MODE_W-1:0]    head_m;

  always_comb begin
    head_m           = '0;
    head_m[MODE_SUB] = sub;
    head_m[MODE_SGN] = sgn;
    head_m[MODE_SAT] = sat;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // A - B - ci == A + ~B + !ci: one adder serves both modes.
      assign st_v[0] = in_valid;
      assign st_a[0] = a;
      assign st_b[0] = sub ? ~b : b;
      assign st_c[0] = sub ? ~ci : ci;
      assign st_s[0] = '0;
      assign st_m[0] = head_m;
    end else begin : g_body
      assign st_v[k] = r_v[k-1];
      assign st_a[k] = r_a[k-1];
      assign st_b[k] = r_b[k-1];
      assign st_s[k] = r_s[k-1];
      assign st_c[k] = r_c[k-1];
      assign st_m[k] = r_m[k-1];
    end

    logic [SL-1:0] ss;

    for (genvar j = 0; j < NCH; j++) begin : g_chunk
      logic             cin_j;
      logic             cout_j;
      logic             co;
      logic             gp;
      logic [CHUNK-1:0] cs;

      if (j == 0) begin : g_c0
        assign cin_j = st_c[k];
      end else begin : g_cn
        assign cin_j = g_chunk[j-1].cout_j;
      end

      cla_chunk #(.N(CHUNK)) u_cla (
        .a    (st_a[k][k*SL + j*CHUNK +: CHUNK]),
        .b    (st_b[k][k*SL + j*CHUNK +: CHUNK]),
        .cin  (cin_j),
        .s    (cs),
        .cout (co),
        .gp   (gp)
      );

      assign ss[j*CHUNK +: CHUNK] = cs;
      // A fully propagating group passes its carry-in straight through.
      assign cout_j = gp ? cin_j : co;
    end

    assign nx_c[k] = g_chunk[NCH-1].cout_j;
    // Slices at and above k are still zero in st_s, so OR merges cleanly.
    assign nx_s[k] = st_s[k] | (WIDTH'(ss) << (k * SL));
  end

  // Final stage: flags and saturation on the completed raw result.
  logic [WIDTH-1:0]  raw;
  logic [WIDTH-1:0]  res;
  logic [WIDTH-1:0]  sat_v;
  logic [MODE_W-1:0] fm;
  logic              cf;
  logic              sov;
  logic              vf;

  assign raw   = nx_s[LAST];
  assign fm    = st_m[LAST];
  assign cf    = fm[MODE_SUB] ? ~nx_c[LAST] : nx_c[LAST];
  assign sov   = (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &&
                 (raw[WIDTH-1] != st_a[LAST][WIDTH-1]);
  assign vf    = fm[MODE_SGN] ? sov : cf;
  assign sat_v = WIDTH'(sat_value(fm[MODE_SGN], fm[MODE_SUB], raw[WIDTH-1], WIDTH));
  assign res   = (fm[MODE_SAT] && vf) ? sat_v : raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAST; k++) begin
        r_v[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
        r_m[k] <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cflag     <= 1'b0;
      vflag     <= 1'b0;
      zflag     <= 1'b0;
      nflag     <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < LAST; k++) begin
        r_v[k] <= st_v[k];
        r_a[k] <= st_a[k];
        r_b[k] <= st_b[k];
        r_s[k] <= nx_s[k];
        r_c[k] <= nx_c[k];
        r_m[k] <= st_m[k];
      end
      out_valid <= st_v[LAST];
      // Bubbles leave the last result visible instead of loading junk.
      if (st_v[LAST]) begin
        sum   <= res;
        cflag <= cf;
        vflag <= vf;
        zflag <= (res == '0);
        nflag <= res[WIDTH-1];
      end
    end
  end

endmodule
